// File: rtl/serial_tx_piso_pkg.sv
`default_nettype none
// ============================================================================
//  serial_tx_piso_pkg
//  Shared state encodings and default word width for the serial PISO sender.
//  Revision: 1.0
// ============================================================================
package serial_tx_piso_pkg;

   localparam int unsigned WIDTH_DEFAULT = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_DONE  = 2'b10
   } state_e;

endpackage
`default_nettype wire

// File: rtl/serial_tx_piso.sv
`default_nettype none
// ============================================================================
//  serial_tx_piso
//  Parallel-in serial-out sender, LSB first, paced by Enable, with Done pulse.
//  Revision: 1.0
// ============================================================================
module serial_tx_piso
   import serial_tx_piso_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
   input  logic             Ck,
   input  logic             Reset,
   input  logic             Load,
   input  logic [WIDTH-1:0] D,
   input  logic             Enable,
   output logic             SO,
   output logic             SOValid,
   output logic             Busy,
   output logic             Done
);

   localparam int unsigned     CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic             so_q,    busy_q, done_q;

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (Load) begin
               shreg_d = D;
               cnt_d   = '0;
               state_d = ST_SHIFT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            if (Enable) begin
               shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
               // Wrap to zero on the last bit so the counter never exceeds WIDTH-1.
               if (cnt_q == LAST_CNT) begin
                  cnt_d   = '0;
                  state_d = ST_DONE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs are registered from the next-state so they line up with state_q.
   always_ff @(posedge Ck) begin
      if (Reset) begin
         state_q <= ST_IDLE;
         shreg_q <= '0;
         cnt_q   <= '0;
         so_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
         so_q    <= (state_d == ST_SHIFT) ? shreg_d[0] : 1'b0;
         busy_q  <= (state_d == ST_SHIFT);
         done_q  <= (state_d == ST_DONE);
      end
   end

   assign SO      = so_q;
   assign Busy    = busy_q;
   assign Done    = done_q;
   assign SOValid = busy_q & Enable;

endmodule
`default_nettype wire

// File: tb/tb_serial_tx_piso.sv
`default_nettype none
// ============================================================================
//  tb_serial_tx_piso
//  Table-driven check of serial_tx_piso plus loopback into a 4-bit SIPO model.
//  Revision: 1.0
// ============================================================================
module tb_serial_tx_piso;

   logic       Ck = 1'b0;
   logic       Reset;
   logic       Load;
   logic [3:0] D;
   logic       Enable;
   logic       SO, SOValid, Busy, Done;

   int checks   = 0;
   int failures = 0;

   serial_tx_piso #(.WIDTH(4)) dut (
      .Ck      (Ck),
      .Reset   (Reset),
      .Load    (Load),
      .D       (D),
      .Enable  (Enable),
      .SO      (SO),
      .SOValid (SOValid),
      .Busy    (Busy),
      .Done    (Done)
   );

   always #7 Ck = ~Ck;

   typedef struct {
      logic       rst;
      logic       load;
      logic [3:0] d;
      logic       en;
      logic       so;
      logic       vld;
      logic       busy;
      logic       done;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(input logic rst, input logic load, input logic [3:0] d,
                               input logic en, input logic so, input logic vld,
                               input logic busy, input logic done);
      vec_t v;
      v.rst = rst; v.load = load; v.d = d; v.en = en;
      v.so = so; v.vld = vld; v.busy = busy; v.done = done;
      tbl.push_back(v);
   endfunction

   task automatic chk(input string name, input int idx, input logic got, input logic exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s step %0d: got %b expected %b", name, idx, got, exp);
      end
   endtask

   task automatic chk_int(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   // Loopback into a right-shifting SIPO model; enable pattern given as a bit mask per cycle.
   task automatic loopback(input string name, input logic [3:0] dat,
                           input logic [15:0] en_pat, input int exp_cycles);
      logic [3:0] rxq;
      int         cyc;
      bit         seen;
      rxq  = 4'b0000;
      seen = 0;
      Load = 1'b1; D = dat; Enable = 1'b1; Reset = 1'b0;
      @(negedge Ck);
      Load = 1'b0; D = 4'b0000;
      for (int c = 1; c <= 30 && !seen; c++) begin
         Enable = en_pat[c-1];
         #1;
         if (Done) begin
            seen = 1;
            cyc  = c;
            checks++;
            if (rxq !== dat) begin
               failures++;
               $display("FAIL %s rxq: got %b expected %b", name, rxq, dat);
            end
            chk_int({name, " latency"}, cyc, exp_cycles);
         end else if (SOValid) begin
            rxq = {SO, rxq[3:1]};
         end
         @(negedge Ck);
      end
      if (!seen) begin
         checks++;
         failures++;
         $display("FAIL %s timeout: got no Done expected Done within 30 cycles", name);
      end
      Enable = 1'b1;
      @(negedge Ck);
   endtask

   initial begin
      // rst load d en | so vld busy done
      // Basic transfer of 1011
      add(0,1,4'b1011,1, 0,0,0,0);
      add(0,0,4'b0000,1, 1,1,1,0);
      add(0,0,4'b0000,1, 1,1,1,0);
      add(0,0,4'b0000,1, 0,1,1,0);
      add(0,0,4'b0000,1, 1,1,1,0);
      add(0,0,4'b0000,1, 0,0,0,1);
      add(0,0,4'b0000,1, 0,0,0,0);
      // 0110 with a two-cycle Enable stall after the second bit
      add(0,1,4'b0110,1, 0,0,0,0);
      add(0,0,4'b0000,1, 0,1,1,0);
      add(0,0,4'b0000,1, 1,1,1,0);
      add(0,0,4'b0000,0, 1,0,1,0);
      add(0,0,4'b0000,0, 1,0,1,0);
      add(0,0,4'b0000,1, 1,1,1,0);
      add(0,0,4'b0000,1, 0,1,1,0);
      add(0,0,4'b0000,1, 0,0,0,1);
      add(0,0,4'b0000,0, 0,0,0,0);
      // Load of 1111 during SHIFT of 0001 is ignored
      add(0,1,4'b0001,1, 0,0,0,0);
      add(0,1,4'b1111,1, 1,1,1,0);
      add(0,1,4'b1111,1, 0,1,1,0);
      add(0,1,4'b1111,1, 0,1,1,0);
      add(0,0,4'b1111,1, 0,1,1,0);
      add(0,0,4'b0000,1, 0,0,0,1);
      add(0,0,4'b0000,1, 0,0,0,0);
      add(0,0,4'b0000,1, 0,0,0,0);
      // Back-to-back: 0101 then 0011 loaded in the DONE cycle
      add(0,1,4'b0101,1, 0,0,0,0);
      add(0,0,4'b0000,1, 1,1,1,0);
      add(0,0,4'b0000,1, 0,1,1,0);
      add(0,0,4'b0000,1, 1,1,1,0);
      add(0,0,4'b0000,1, 0,1,1,0);
      add(0,1,4'b0011,1, 0,0,0,1);
      add(0,0,4'b0000,1, 1,1,1,0);
      add(0,0,4'b0000,1, 1,1,1,0);
      add(0,0,4'b0000,1, 0,1,1,0);
      add(0,0,4'b0000,1, 0,1,1,0);
      add(0,0,4'b0000,1, 0,0,0,1);
      add(0,0,4'b0000,1, 0,0,0,0);
      // Reset after the second bit of 1010 aborts without Done
      add(0,1,4'b1010,1, 0,0,0,0);
      add(0,0,4'b0000,1, 0,1,1,0);
      add(0,0,4'b0000,1, 1,1,1,0);
      add(1,0,4'b0000,1, 0,1,1,0);
      add(0,0,4'b0000,1, 0,0,0,0);
      add(0,0,4'b0000,1, 0,0,0,0);
      add(0,0,4'b0000,1, 0,0,0,0);
      // Reset wins over Load in IDLE
      add(1,1,4'b1111,1, 0,0,0,0);
      add(0,0,4'b0000,1, 0,0,0,0);

      Reset = 1'b1; Load = 1'b0; D = 4'b0000; Enable = 1'b0;
      #25;
      Reset = 1'b0;
      @(negedge Ck);
      #1;
      chk("reset SO", -1, SO, 1'b0);
      chk("reset SOValid", -1, SOValid, 1'b0);
      chk("reset Busy", -1, Busy, 1'b0);
      chk("reset Done", -1, Done, 1'b0);

      for (int i = 0; i < tbl.size(); i++) begin
         Reset  = tbl[i].rst;
         Load   = tbl[i].load;
         D      = tbl[i].d;
         Enable = tbl[i].en;
         #1;
         chk("SO", i, SO, tbl[i].so);
         chk("SOValid", i, SOValid, tbl[i].vld);
         chk("Busy", i, Busy, tbl[i].busy);
         chk("Done", i, Done, tbl[i].done);
         @(negedge Ck);
      end
      Reset = 1'b0; Load = 1'b0; Enable = 1'b1;
      @(negedge Ck);

      loopback("loop1101", 4'b1101, 16'hFFFF, 5);
      // Stall pattern (bit0 = cycle 1): 1,0,1,1,0,0,1,1,... -> 3 stall cycles
      loopback("loop1010_stall", 4'b1010, 16'b1111_1111_1100_1101, 8);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
